// File: rtl/warp_barrier_unit.sv
`default_nettype none
// ============================================================================
// Module   : warp_barrier_unit
// Purpose  : Hardware barrier tracker. Counts warp arrivals per barrier slot,
//            keeps arrived warps stalled, and emits one registered release
//            pulse with the warp mask when the last participant arrives.
// Revision : 1.0  initial release
// ============================================================================
module warp_barrier_unit #(
    parameter int NUM_WARPS    = 4,
    parameter int NUM_BARRIERS = 4,
    parameter int NW_BITS      = $clog2(NUM_WARPS),
    parameter int NB_BITS      = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 bar_valid,
    input  logic [NW_BITS-1:0]   bar_wid,
    input  logic [NB_BITS-1:0]   bar_id,
    input  logic [NW_BITS-1:0]   bar_size_m1,
    output logic                 release_valid,
    output logic [NB_BITS-1:0]   release_id,
    output logic [NUM_WARPS-1:0] release_wmask,
    output logic [NUM_WARPS-1:0] stalled_wmask,
    output logic                 err,
    input  logic                 err_clr
);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_WAITING = 1'b1
    } slot_state_t;

    // Per-slot state, current and next
    slot_state_t          state_q [NUM_BARRIERS];
    slot_state_t          state_d [NUM_BARRIERS];
    logic [NW_BITS-1:0]   size_q  [NUM_BARRIERS];
    logic [NW_BITS-1:0]   size_d  [NUM_BARRIERS];
    logic [NW_BITS-1:0]   count_q [NUM_BARRIERS];
    logic [NW_BITS-1:0]   count_d [NUM_BARRIERS];
    logic [NUM_WARPS-1:0] wmask_q [NUM_BARRIERS];
    logic [NUM_WARPS-1:0] wmask_d [NUM_BARRIERS];

    // Registered-output next values
    logic                 rel_valid_d;
    logic [NB_BITS-1:0]   rel_id_d;
    logic [NUM_WARPS-1:0] rel_wmask_d;
    logic [NUM_WARPS-1:0] stalled_d;
    logic                 err_event;
    logic                 err_d;

    logic [NUM_WARPS-1:0] warp_onehot;
    logic [NW_BITS-1:0]   count_inc;

    assign warp_onehot = NUM_WARPS'(1) << bar_wid;
    assign count_inc   = count_q[bar_id] + NW_BITS'(1);

    // Next-state: only the addressed slot can change in a given cycle
    always_comb begin
        state_d     = state_q;
        size_d      = size_q;
        count_d     = count_q;
        wmask_d     = wmask_q;
        rel_valid_d = 1'b0;
        rel_id_d    = '0;
        rel_wmask_d = '0;
        err_event   = 1'b0;

        if (bar_valid) begin
            // A warp already held by a different slot is still processed,
            // but it is a protocol violation. Same-slot duplicates are
            // flagged below and otherwise ignored.
            if (stalled_wmask[bar_wid] && !wmask_q[bar_id][bar_wid]) begin
                err_event = 1'b1;
            end

            case (state_q[bar_id])
                ST_IDLE: begin
                    if (bar_size_m1 == '0) begin
                        // Single-participant barrier: release without stalling
                        rel_valid_d = 1'b1;
                        rel_id_d    = bar_id;
                        rel_wmask_d = warp_onehot;
                    end else begin
                        state_d[bar_id] = ST_WAITING;
                        size_d[bar_id]  = bar_size_m1;
                        count_d[bar_id] = '0;
                        wmask_d[bar_id] = warp_onehot;
                    end
                end

                ST_WAITING: begin
                    // Mismatched size is reported; the latched size governs
                    if (bar_size_m1 != size_q[bar_id]) begin
                        err_event = 1'b1;
                    end

                    if (wmask_q[bar_id][bar_wid]) begin
                        err_event = 1'b1;
                    end else if (count_inc == size_q[bar_id]) begin
                        rel_valid_d     = 1'b1;
                        rel_id_d        = bar_id;
                        rel_wmask_d     = wmask_q[bar_id] | warp_onehot;
                        state_d[bar_id] = ST_IDLE;
                        size_d[bar_id]  = '0;
                        count_d[bar_id] = '0;
                        wmask_d[bar_id] = '0;
                    end else begin
                        count_d[bar_id] = count_inc;
                        wmask_d[bar_id] = wmask_q[bar_id] | warp_onehot;
                    end
                end

                default: begin
                    state_d[bar_id] = ST_IDLE;
                end
            endcase
        end

        // Stall view follows the next slot masks so it updates with the arrival
        stalled_d = '0;
        for (int i = 0; i < NUM_BARRIERS; i++) begin
            if (state_d[i] == ST_WAITING) begin
                stalled_d = stalled_d | wmask_d[i];
            end
        end

        // Sticky error; a new error beats a simultaneous clear
        err_d = err_event | (err & ~err_clr);
    end

    // Slot state registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_BARRIERS; i++) begin
                state_q[i] <= ST_IDLE;
                size_q[i]  <= '0;
                count_q[i] <= '0;
                wmask_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_BARRIERS; i++) begin
                state_q[i] <= state_d[i];
                size_q[i]  <= size_d[i];
                count_q[i] <= count_d[i];
                wmask_q[i] <= wmask_d[i];
            end
        end
    end

    // Output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            release_valid <= 1'b0;
            release_id    <= '0;
            release_wmask <= '0;
            stalled_wmask <= '0;
            err           <= 1'b0;
        end else begin
            release_valid <= rel_valid_d;
            release_id    <= rel_id_d;
            release_wmask <= rel_wmask_d;
            stalled_wmask <= stalled_d;
            err           <= err_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_warp_barrier_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_warp_barrier_unit
// Purpose  : Directed self-checking bench for warp_barrier_unit; expected
//            release records are queued on each request and popped when the
//            registered outputs appear one cycle later.
// Revision : 1.0  initial release
// ============================================================================
module tb_warp_barrier_unit;

    localparam int NUM_WARPS    = 4;
    localparam int NUM_BARRIERS = 4;
    localparam int NW_BITS      = 2;
    localparam int NB_BITS      = 2;

    logic                 clk;
    logic                 reset_n;
    logic                 bar_valid;
    logic [NW_BITS-1:0]   bar_wid;
    logic [NB_BITS-1:0]   bar_id;
    logic [NW_BITS-1:0]   bar_size_m1;
    logic                 release_valid;
    logic [NB_BITS-1:0]   release_id;
    logic [NUM_WARPS-1:0] release_wmask;
    logic [NUM_WARPS-1:0] stalled_wmask;
    logic                 err;
    logic                 err_clr;

    typedef struct {
        logic        rv;
        logic [31:0] rid;
        logic [31:0] rmask;
        logic [31:0] stall;
        logic        e;
    } exp_t;

    exp_t sb[$];
    int   tests;
    int   fails;

    warp_barrier_unit #(
        .NUM_WARPS   (NUM_WARPS),
        .NUM_BARRIERS(NUM_BARRIERS),
        .NW_BITS     (NW_BITS),
        .NB_BITS     (NB_BITS)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .bar_valid    (bar_valid),
        .bar_wid      (bar_wid),
        .bar_id       (bar_id),
        .bar_size_m1  (bar_size_m1),
        .release_valid(release_valid),
        .release_id   (release_id),
        .release_wmask(release_wmask),
        .stalled_wmask(stalled_wmask),
        .err          (err),
        .err_clr      (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Drive one cycle (request or idle), queue the expectation, then compare
    task automatic step(input string tag, input logic v, input int wid, input int id,
                        input int sm1, input logic rv, input int rmask,
                        input int stall, input logic e);
        exp_t x;
        bar_valid   = v;
        bar_wid     = NW_BITS'(wid);
        bar_id      = NB_BITS'(id);
        bar_size_m1 = NW_BITS'(sm1);
        x.rv    = rv;
        x.rid   = rv ? 32'(id) : 32'd0;
        x.rmask = 32'(rmask);
        x.stall = 32'(stall);
        x.e     = e;
        sb.push_back(x);
        @(posedge clk);
        #1;
        bar_valid = 1'b0;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            x = sb.pop_front();
            chk({tag, "_rvalid"}, 32'(release_valid), 32'(x.rv));
            if (x.rv) begin
                chk({tag, "_rid"}, 32'(release_id), x.rid);
                chk({tag, "_rmask"}, 32'(release_wmask), x.rmask);
            end
            chk({tag, "_stall"}, 32'(stalled_wmask), x.stall);
            chk({tag, "_err"}, 32'(err), 32'(x.e));
        end
    endtask

    initial begin
        tests       = 0;
        fails       = 0;
        reset_n     = 1'b0;
        bar_valid   = 1'b0;
        bar_wid     = '0;
        bar_id      = '0;
        bar_size_m1 = '0;
        err_clr     = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_rvalid", 32'(release_valid), 32'd0);
        chk("rst_rid", 32'(release_id), 32'd0);
        chk("rst_rmask", 32'(release_wmask), 32'd0);
        chk("rst_stall", 32'(stalled_wmask), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Four-warp barrier on slot 0
        step("s0_w0", 1, 0, 0, 3, 0, 0, 4'b0001, 0);
        step("s0_w1", 1, 1, 0, 3, 0, 0, 4'b0011, 0);
        step("s0_w2", 1, 2, 0, 3, 0, 0, 4'b0111, 0);
        step("s0_w3", 1, 3, 0, 3, 1, 4'b1111, 4'b0000, 0);

        // Single-participant barrier releases immediately
        step("s1_single", 1, 2, 1, 0, 1, 4'b0100, 4'b0000, 0);
        step("idle0", 0, 0, 0, 0, 0, 0, 4'b0000, 0);

        // Duplicate arrival on slot 2
        step("s2_w1", 1, 1, 2, 2, 0, 0, 4'b0010, 0);
        step("s2_dup", 1, 1, 2, 2, 0, 0, 4'b0010, 1);
        step("s2_w0", 1, 0, 2, 2, 0, 0, 4'b0011, 1);
        step("s2_w3", 1, 3, 2, 2, 1, 4'b1011, 4'b0000, 1);
        err_clr = 1'b1;
        step("errclr", 0, 0, 0, 0, 0, 0, 4'b0000, 0);
        err_clr = 1'b0;

        // Interleaved slots 0 and 3
        step("il_s0w0", 1, 0, 0, 1, 0, 0, 4'b0001, 0);
        step("il_s3w2", 1, 2, 3, 1, 0, 0, 4'b0101, 0);
        step("il_s0w1", 1, 1, 0, 1, 1, 4'b0011, 4'b0100, 0);
        step("il_s3w3", 1, 3, 3, 1, 1, 4'b1100, 4'b0000, 0);

        // Asynchronous reset discards a partial barrier
        step("rs_w0", 1, 0, 0, 3, 0, 0, 4'b0001, 0);
        step("rs_w1", 1, 1, 0, 3, 0, 0, 4'b0011, 0);
        #1;
        reset_n = 1'b0;
        #1;
        chk("arst_rvalid", 32'(release_valid), 32'd0);
        chk("arst_stall", 32'(stalled_wmask), 32'd0);
        chk("arst_err", 32'(err), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        step("rs_w2", 1, 2, 0, 3, 0, 0, 4'b0100, 0);
        step("rs_w3", 1, 3, 0, 3, 0, 0, 4'b1100, 0);
        step("rs_w0b", 1, 0, 0, 3, 0, 0, 4'b1101, 0);
        step("rs_w1b", 1, 1, 0, 3, 1, 4'b1111, 4'b0000, 0);

        // Size mismatch on slot 1 keeps the latched size
        step("sm_w0", 1, 0, 1, 2, 0, 0, 4'b0001, 0);
        step("sm_w1", 1, 1, 1, 1, 0, 0, 4'b0011, 1);
        step("sm_w2", 1, 2, 1, 2, 1, 4'b0111, 4'b0000, 1);

        // Error and clear in the same cycle: error wins
        step("cx_s0w0", 1, 0, 0, 1, 0, 0, 4'b0001, 1);
        err_clr = 1'b1;
        step("cx_other", 1, 0, 1, 0, 1, 4'b0001, 4'b0001, 1);
        step("cx_clr", 0, 0, 0, 0, 0, 0, 4'b0001, 0);
        err_clr = 1'b0;
        step("cx_s0w1", 1, 1, 0, 1, 1, 4'b0011, 4'b0000, 0);
        step("idle1", 0, 0, 0, 0, 0, 0, 4'b0000, 0);

        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/warp_barrier_unit.md
Name: warp_barrier_unit

Overview:
- Consumer of the barrier request record emitted by the GPU control unit: valid, barrier id, participant count minus one.
- Tracks arrivals per hardware barrier and holds arriving warps stalled.
- When the last participant arrives, issues a single release pulse carrying the warp mask to free.
- Sits between the GPU unit's barrier output and the warp scheduler's stall/resume logic.

Parameters:
- NUM_WARPS, 4, warps per core; must be >= 2.
- NUM_BARRIERS, 4, hardware barrier slots.
- NW_BITS, clog2(NUM_WARPS), warp-id / size width.
- NB_BITS, clog2(NUM_BARRIERS), barrier-id width; minimum 1.

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset; asynchronous, active-low.
- bar_valid  in  1  barrier request strobe; one request per cycle, always accepted.
- bar_wid  in  NW_BITS  issuing warp.
- bar_id  in  NB_BITS  barrier slot.
- bar_size_m1  in  NW_BITS  participant count minus one.
- release_valid  out  1  one-cycle release pulse.
- release_id  out  NB_BITS  barrier being released.
- release_wmask  out  NUM_WARPS  warps to resume.
- stalled_wmask  out  NUM_WARPS  warps currently waiting on any barrier.
- err  out  1  sticky protocol-error flag.
- err_clr  in  1  clears err.

Behaviour:
Per-slot state:
- active: 1 bit.
- size_m1: NW_BITS, latched at first arrival.
- count: NW_BITS, arrivals so far minus one.
- wmask: NUM_WARPS.

Reset (reset_n low, asynchronous):
- All slots inactive; count, size and mask are 0.
- release_valid=0, release_id=0, release_wmask=0, stalled_wmask=0, err=0.
- Reset mid-operation discards all pending barriers. No release is emitted for discarded barriers.

Slot state machine: IDLE -> WAITING -> IDLE.

On bar_valid at cycle t, for slot s=bar_id and warp w=bar_wid:
- IDLE with bar_size_m1==0:
  - Immediate release.
  - At t+1: release_valid=1, release_id=s, release_wmask=onehot(w).
  - Slot stays IDLE; w never appears in stalled_wmask.
- IDLE with bar_size_m1>0:
  - Go to WAITING; latch size_m1; count=0; wmask=onehot(w).
  - At t+1: stalled_wmask[w]=1.
- WAITING, w not in wmask, count+1 < size_m1:
  - count++; set wmask[w].
  - At t+1: stalled_wmask[w]=1.
- WAITING, w not in wmask, count+1 == size_m1 (last arrival):
  - At t+1: release_valid=1, release_id=s, release_wmask = wmask | onehot(w).
  - Those bits are clear in stalled_wmask from t+1.
  - Slot returns to IDLE with count=0 and wmask=0.
- WAITING, w already in wmask (duplicate arrival):
  - No state change.
  - err=1 at t+1.
- WAITING with bar_size_m1 != latched size_m1:
  - err=1 at t+1.
  - Arrival is still processed using the latched size.

Outputs and timing:
- release_valid is registered, so latency is exactly 1 cycle from request to release. It is low in every cycle without a completing arrival.
- stalled_wmask is registered and equals the OR of all active slots' wmask.
- A warp stalled on one slot that arrives at a different slot is processed normally and sets err. Stall bits stay set until the owning slot releases.
- Back-to-back requests to the same slot in consecutive cycles are processed in order with no bubble. The slot is reusable in the cycle immediately after its release request.

Error flag:
- err is sticky.
- err_clr clears it next cycle.
- If err_clr and a new error occur in the same cycle, the error wins and err stays 1.

Width and arithmetic:
- count and size use NW_BITS.
- bar_size_m1 ranges 0..NUM_WARPS-1, so no overflow is possible.

Test Plan:
- Slot 0, size_m1=3, warps 0,1,2,3 arrive on cycles 0..3.
  - stalled_wmask reads 0001, 0011, 0111 at cycles 1..3.
  - Cycle 4: release_valid=1, release_id=0, release_wmask=1111, stalled_wmask=0000.
- Warp 2 arrives at slot 1 with size_m1=0.
  - Next cycle: release_valid=1, release_id=1, release_wmask=0100.
  - stalled_wmask stays 0000.
- Slot 2, size_m1=2: warp 1 arrives twice, then warps 0 and 3 arrive.
  - err=1 after the second warp-1 arrival.
  - Release occurs only after warp 3, with release_wmask=1011.
  - Asserting err_clr then drops err.
- Interleaved slot 0 (warps 0,1; size_m1=1) and slot 3 (warps 2,3; size_m1=1), arrivals on alternating cycles.
  - Two separate release pulses with release_id 0 then 3.
  - release_wmask is 0011 then 1100.
- Slot 0 size_m1=3 with warps 0 and 1 arrived; reset_n pulsed low mid-cycle.
  - All outputs are 0 immediately (asynchronously).
  - Subsequent arrivals of warps 2 and 3 do not release; the slot restarts from IDLE.
- Slot 1: first arrival with size_m1=2, second arrival with size_m1=1.
  - err=1.
  - Release occurs only on the third distinct warp.
